// File: rtl/csr_cmt.sv
// Commit-side CSR controller: performs CSR read/write, raises trap/ertn pulses, flushes and
// offers a redirect PC to fetch. Optional interrupt sampling under `CSR_CMT_INT_EN`.
module csr_cmt #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [2:0]  wb_op,
    input  logic [13:0] wb_csr_num,
    input  logic [31:0] wb_rj,
    input  logic [31:0] wb_rd,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        wb_ex_req,
    input  logic [5:0]  wb_ecode_req,
    input  logic [8:0]  wb_esubcode_req,
    output logic        csr_re,
    output logic        csr_we,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    input  logic [31:0] csr_rvalue,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [31:0] cmt_pc,
    output logic [31:0] cmt_vaddr,
    output logic [5:0]  cmt_ecode,
    output logic [8:0]  cmt_esubcode,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ertn_entry,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [2:0] {StIdle, StAcc, StTrap, StRet, StRedir} state_e;

    state_e      state_q;
    logic        ready_q;
    logic        csr_re_q, csr_we_q, rf_we_q, wb_ex_q, ertn_flush_q, flush_q;
    logic [13:0] csr_num_q;
    logic [31:0] csr_wmask_q, csr_wvalue_q;
    logic [31:0] cmt_pc_q, cmt_vaddr_q;
    logic [5:0]  cmt_ecode_q;
    logic [8:0]  cmt_esubcode_q;
    logic        redirect_valid_q;
    logic [31:0] redirect_pc_q;
    logic        int_q;

`ifdef CSR_CMT_INT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            int_q <= 1'b0;
        end else if (state_q == StIdle) begin
            int_q <= has_int;
        end
    end
`else
    logic unused_has_int;
    assign int_q          = 1'b0;
    assign unused_has_int = has_int;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= StIdle;
            ready_q          <= 1'b0;
            csr_re_q         <= 1'b0;
            csr_we_q         <= 1'b0;
            rf_we_q          <= 1'b0;
            wb_ex_q          <= 1'b0;
            ertn_flush_q     <= 1'b0;
            flush_q          <= 1'b0;
            csr_num_q        <= 14'h0;
            csr_wmask_q      <= 32'h0;
            csr_wvalue_q     <= 32'h0;
            cmt_pc_q         <= 32'h0;
            cmt_vaddr_q      <= 32'h0;
            cmt_ecode_q      <= 6'h0;
            cmt_esubcode_q   <= 9'h0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
        end else begin
            // Pulses last exactly one cycle unless re-armed below.
            csr_re_q     <= 1'b0;
            csr_we_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            wb_ex_q      <= 1'b0;
            ertn_flush_q <= 1'b0;
            flush_q      <= 1'b0;
            csr_wmask_q  <= 32'h0;
            csr_wvalue_q <= 32'h0;
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b1;
                    if (wb_valid && ready_q) begin
                        csr_num_q <= wb_csr_num;
                        if (int_q || wb_ex_req) begin
                            state_q        <= StTrap;
                            ready_q        <= 1'b0;
                            wb_ex_q        <= 1'b1;
                            flush_q        <= 1'b1;
                            cmt_pc_q       <= wb_pc;
                            cmt_vaddr_q    <= wb_vaddr;
                            cmt_ecode_q    <= int_q ? 6'h00 : wb_ecode_req;
                            cmt_esubcode_q <= int_q ? 9'h000 : wb_esubcode_req;
                        end else begin
                            unique case (wb_op)
                                3'd1: begin
                                    state_q  <= StAcc;
                                    ready_q  <= 1'b0;
                                    csr_re_q <= 1'b1;
                                    rf_we_q  <= 1'b1;
                                end
                                3'd2, 3'd3: begin
                                    state_q       <= StAcc;
                                    ready_q       <= 1'b0;
                                    csr_re_q      <= 1'b1;
                                    rf_we_q       <= 1'b1;
                                    csr_we_q      <= 1'b1;
                                    flush_q       <= 1'b1;
                                    csr_wmask_q   <= (wb_op == 3'd2) ? 32'hffffffff : wb_rj;
                                    csr_wvalue_q  <= wb_rd;
                                    redirect_pc_q <= wb_pc + 32'd4;
                                end
                                3'd4: begin
                                    state_q      <= StRet;
                                    ready_q      <= 1'b0;
                                    ertn_flush_q <= 1'b1;
                                    flush_q      <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                StAcc: begin
                    // A CSR write changes machine state, so refetch from pc+4.
                    state_q          <= flush_q ? StRedir : StIdle;
                    ready_q          <= !flush_q;
                    redirect_valid_q <= flush_q;
                end
                StTrap: begin
                    state_q          <= StRedir;
                    redirect_pc_q    <= ex_entry;
                    redirect_valid_q <= 1'b1;
                end
                StRet: begin
                    state_q          <= StRedir;
                    redirect_pc_q    <= ertn_entry;
                    redirect_valid_q <= 1'b1;
                end
                StRedir: begin
                    if (redirect_ready) begin
                        state_q          <= StIdle;
                        ready_q          <= 1'b1;
                        redirect_valid_q <= 1'b0;
                        redirect_pc_q    <= RESET_PC;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign wb_ready       = ready_q;
    assign csr_re         = csr_re_q;
    assign csr_we         = csr_we_q;
    assign csr_num        = csr_num_q;
    assign csr_wmask      = csr_wmask_q;
    assign csr_wvalue     = csr_wvalue_q;
    assign wb_ex          = wb_ex_q;
    assign ertn_flush     = ertn_flush_q;
    assign cmt_pc         = cmt_pc_q;
    assign cmt_vaddr      = cmt_vaddr_q;
    assign cmt_ecode      = cmt_ecode_q;
    assign cmt_esubcode   = cmt_esubcode_q;
    assign rf_we          = rf_we_q;
    assign rf_wdata       = rf_we_q ? csr_rvalue : 32'h0;
    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_cmt.sv
// Randomized self-checking bench for csr_cmt against a per-transaction behavioural model.
module tb_csr_cmt;

    localparam logic [31:0] ResetPc = 32'h1c000000;
`ifdef CSR_CMT_INT_EN
    localparam bit IntEn = 1'b1;
`else
    localparam bit IntEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        wb_valid = 1'b0;
    logic        wb_ready;
    logic [2:0]  wb_op = '0;
    logic [13:0] wb_csr_num = '0;
    logic [31:0] wb_rj = '0, wb_rd = '0, wb_pc = '0, wb_vaddr = '0;
    logic        wb_ex_req = 1'b0;
    logic [5:0]  wb_ecode_req = '0;
    logic [8:0]  wb_esubcode_req = '0;
    logic        csr_re, csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue;
    logic [31:0] csr_rvalue = '0;
    logic        wb_ex, ertn_flush;
    logic [31:0] cmt_pc, cmt_vaddr;
    logic [5:0]  cmt_ecode;
    logic [8:0]  cmt_esubcode;
    logic        has_int = 1'b0;
    logic [31:0] ex_entry = '0, ertn_entry = '0;
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic        flush, redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus record for one transaction.
    logic [2:0]  s_op;
    logic [13:0] s_num;
    logic [31:0] s_rj, s_rd, s_pc, s_vaddr, s_rvalue, s_exent, s_ertent;
    logic        s_ex, s_int;
    logic [5:0]  s_ecode;
    logic [8:0]  s_esub;
    int          s_hold;

    csr_cmt #(.RESET_PC(ResetPc)) dut (
        .clk(clk), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_op(wb_op),
        .wb_csr_num(wb_csr_num), .wb_rj(wb_rj), .wb_rd(wb_rd), .wb_pc(wb_pc),
        .wb_vaddr(wb_vaddr), .wb_ex_req(wb_ex_req), .wb_ecode_req(wb_ecode_req),
        .wb_esubcode_req(wb_esubcode_req), .csr_re(csr_re), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .csr_rvalue(csr_rvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush), .cmt_pc(cmt_pc),
        .cmt_vaddr(cmt_vaddr), .cmt_ecode(cmt_ecode), .cmt_esubcode(cmt_esubcode),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry), .rf_we(rf_we),
        .rf_wdata(rf_wdata), .flush(flush), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_stim();
        s_op = 3'd0; s_num = '0; s_rj = '0; s_rd = '0; s_pc = '0; s_vaddr = '0;
        s_rvalue = '0; s_exent = '0; s_ertent = '0; s_ex = 1'b0; s_int = 1'b0;
        s_ecode = '0; s_esub = '0; s_hold = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".wb_ready"}, 32'(wb_ready), 32'd0);
        check_eq({tag, ".redirect_valid"}, 32'(redirect_valid), 32'd0);
        check_eq({tag, ".redirect_pc"}, redirect_pc, ResetPc);
        check_eq({tag, ".flush"}, 32'(flush), 32'd0);
        check_eq({tag, ".csr_we"}, 32'(csr_we), 32'd0);
        check_eq({tag, ".wb_ex"}, 32'(wb_ex), 32'd0);
        check_eq({tag, ".cmt_pc"}, cmt_pc, 32'd0);
        check_eq({tag, ".rf_wdata"}, rf_wdata, 32'd0);
    endtask

    // Drive one instruction from the stimulus record and check it end to end.
    task automatic run_txn();
        bit          int_taken, trap, ret, acc, we, redir;
        logic [31:0] tgt;
        logic [5:0]  ec;
        logic [8:0]  es;
        int_taken = IntEn && s_int;
        trap  = int_taken || s_ex;
        ec    = int_taken ? 6'h00 : s_ecode;
        es    = int_taken ? 9'h000 : s_esub;
        ret   = !trap && (s_op == 3'd4);
        acc   = !trap && (s_op >= 3'd1) && (s_op <= 3'd3);
        we    = acc && (s_op != 3'd1);
        redir = trap || ret || we;
        tgt   = trap ? s_exent : (ret ? s_ertent : s_pc + 32'd4);

        @(negedge clk);
        check_eq("idle.wb_ready", 32'(wb_ready), 32'd1);
        has_int = s_int;
        @(negedge clk);
        wb_valid = 1'b1; wb_op = s_op; wb_csr_num = s_num; wb_rj = s_rj; wb_rd = s_rd;
        wb_pc = s_pc; wb_vaddr = s_vaddr; wb_ex_req = s_ex; wb_ecode_req = s_ecode;
        wb_esubcode_req = s_esub; csr_rvalue = s_rvalue; ex_entry = s_exent;
        ertn_entry = s_ertent; redirect_ready = 1'($urandom % 2);
        @(negedge clk);
        wb_valid = 1'b0; has_int = 1'b0;
        check_eq("n1.csr_re", 32'(csr_re), 32'(acc));
        check_eq("n1.rf_we", 32'(rf_we), 32'(acc));
        check_eq("n1.rf_wdata", rf_wdata, acc ? s_rvalue : 32'd0);
        check_eq("n1.csr_we", 32'(csr_we), 32'(we));
        check_eq("n1.csr_wmask", csr_wmask, we ? ((s_op == 3'd2) ? 32'hffffffff : s_rj) : 32'd0);
        check_eq("n1.csr_wvalue", csr_wvalue, we ? s_rd : 32'd0);
        check_eq("n1.wb_ex", 32'(wb_ex), 32'(trap));
        check_eq("n1.ertn_flush", 32'(ertn_flush), 32'(ret));
        check_eq("n1.flush", 32'(flush), 32'(redir));
        check_eq("n1.redirect_valid", 32'(redirect_valid), 32'd0);
        check_eq("n1.wb_ready", 32'(wb_ready), 32'(!(trap || ret || acc)));
        if (acc) check_eq("n1.csr_num", 32'(csr_num), 32'(s_num));
        if (trap) begin
            check_eq("n1.cmt_ecode", 32'(cmt_ecode), 32'(ec));
            check_eq("n1.cmt_esubcode", 32'(cmt_esubcode), 32'(es));
            check_eq("n1.cmt_pc", cmt_pc, s_pc);
            check_eq("n1.cmt_vaddr", cmt_vaddr, s_vaddr);
        end
        if (redir) begin
            @(negedge clk);
            for (int i = 0; i <= s_hold; i++) begin
                check_eq("redir.valid", 32'(redirect_valid), 32'd1);
                check_eq("redir.pc", redirect_pc, tgt);
                check_eq("redir.no_pulse", 32'({wb_ex, ertn_flush, csr_we, flush}), 32'd0);
                redirect_ready = (i == s_hold);
                @(negedge clk);
            end
            redirect_ready = 1'b0;
            check_eq("done.valid", 32'(redirect_valid), 32'd0);
            check_eq("done.wb_ready", 32'(wb_ready), 32'd1);
            check_eq("done.redirect_pc", redirect_pc, ResetPc);
        end else if (acc) begin
            @(negedge clk);
            check_eq("rd.wb_ready", 32'(wb_ready), 32'd1);
            check_eq("rd.valid", 32'(redirect_valid), 32'd0);
            check_eq("rd.rf_we", 32'(rf_we), 32'd0);
        end
        redirect_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        @(negedge clk);
        check_eq("post_reset.wb_ready", 32'(wb_ready), 32'd1);

        // csrrd
        clear_stim(); s_op = 3'd1; s_num = 14'h30; s_rvalue = 32'h12345678; s_pc = 32'h1c000000;
        run_txn();
        // csrxchg
        clear_stim(); s_op = 3'd3; s_num = 14'h6; s_rj = 32'h0000ffff; s_rd = 32'hdeadbeef;
        s_pc = 32'h1c000100; run_txn();
        // csrwr with pc+4 wrapping around
        clear_stim(); s_op = 3'd2; s_rd = 32'h5a5a5a5a; s_pc = 32'hfffffffc; run_txn();
        // exception held three cycles by fetch
        clear_stim(); s_ex = 1'b1; s_ecode = 6'h09; s_esub = 9'h3; s_vaddr = 32'h1001;
        s_exent = 32'h1c008000; s_pc = 32'h1c000040; s_op = 3'd2; s_hold = 3; run_txn();
        // ertn
        clear_stim(); s_op = 3'd4; s_ertent = 32'h1c000200; s_exent = 32'h1c008000; run_txn();
        // interrupt pending one cycle before a csrwr
        clear_stim(); s_op = 3'd2; s_int = 1'b1; s_pc = 32'h1c000300; s_rd = 32'h11;
        s_exent = 32'h1c00a000; run_txn();
        // op encodings 0 and 5..7 do nothing
        clear_stim(); s_op = 3'd6; run_txn();

        for (int n = 0; n < 60; n++) begin
            s_op     = 3'($urandom % 8);
            s_num    = 14'($urandom);
            s_rj     = $urandom;
            s_rd     = $urandom;
            s_pc     = {$urandom, 2'b00} >> 2 << 2;
            s_vaddr  = $urandom;
            s_rvalue = $urandom;
            s_exent  = $urandom;
            s_ertent = $urandom;
            s_ex     = ($urandom % 4) == 0;
            s_int    = ($urandom % 5) == 0;
            s_ecode  = 6'($urandom);
            s_esub   = 9'($urandom);
            s_hold   = int'($urandom % 4);
            run_txn();
        end

        // Reset while a redirect is pending.
        clear_stim();
        @(negedge clk);
        wb_valid = 1'b1; wb_op = 3'd3; wb_rj = 32'hff; wb_rd = 32'h1; wb_pc = 32'h1c000500;
        wb_ex_req = 1'b0;
        @(negedge clk);
        wb_valid = 1'b0;
        @(negedge clk);
        check_eq("midredir.valid", 32'(redirect_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midredir_reset");
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("after_reset.wb_ready", 32'(wb_ready), 32'd1);
        check_eq("after_reset.valid", 32'(redirect_valid), 32'd0);
        check_eq("after_reset.flush", 32'(flush), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
